// File: rtl/icache_miss_entry_table.sv
// rtl/icache_miss_entry_table.sv - i-cache miss entry table: allocate, issue, refill tracking
module icache_miss_entry_table #(
   parameter int NUM_ENTRY     = 4,
   parameter int ENTRY_DEPTH   = 2,
   parameter int ADDR_WIDTH    = 32,
   parameter int WARP_ID_WIDTH = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alloc_valid_i,
   output logic                     alloc_ready_o,
   input  logic [ADDR_WIDTH-1:0]    alloc_addr_i,
   input  logic [WARP_ID_WIDTH-1:0] alloc_warp_id_i,
   output logic [NUM_ENTRY-1:0]     entry_valid_o,
   output logic                     full_o,
   output logic                     mem_req_valid_o,
   input  logic                     mem_req_ready_i,
   output logic [ADDR_WIDTH-1:0]    mem_req_addr_o,
   output logic [ENTRY_DEPTH-1:0]   mem_req_id_o,
   input  logic                     mem_rsp_valid_i,
   input  logic [ENTRY_DEPTH-1:0]   mem_rsp_id_i,
   output logic                     mem_rsp_ready_o,
   output logic                     fill_valid_o,
   output logic [ADDR_WIDTH-1:0]    fill_addr_o,
   output logic [WARP_ID_WIDTH-1:0] fill_warp_id_o,
   output logic                     rsp_err_o
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PENDING  = 2'd1,
      ST_ISSUING  = 2'd2,
      ST_WAIT_RSP = 2'd3
   } entry_state_t;

   entry_state_t               entry_state     [NUM_ENTRY];
   entry_state_t               entry_state_nxt [NUM_ENTRY];
   logic [ADDR_WIDTH-1:0]      entry_addr      [NUM_ENTRY];
   logic [WARP_ID_WIDTH-1:0]   entry_warp      [NUM_ENTRY];

   logic [NUM_ENTRY-1:0]       pend_vec;
   logic [ENTRY_DEPTH-1:0]     alloc_idx;
   logic [ENTRY_DEPTH-1:0]     pend_idx;
   logic                       pend_any;
   logic                       alloc_fire;
   logic                       req_hs;
   logic                       req_load_en;
   logic                       load_fire;
   logic                       rsp_hit;

   assign mem_rsp_ready_o = 1'b1;
   assign full_o          = &entry_valid_o;
   assign alloc_ready_o   = !full_o;

   always_comb begin
      entry_valid_o = '0;
      pend_vec      = '0;
      for (int i = 0; i < NUM_ENTRY; i++) begin
         entry_valid_o[i] = (entry_state[i] != ST_IDLE);
         pend_vec[i]      = (entry_state[i] == ST_PENDING);
      end
   end

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      alloc_idx = '0;
      pend_idx  = '0;
      pend_any  = 1'b0;
      for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
         if (!entry_valid_o[i]) alloc_idx = ENTRY_DEPTH'(i);
         if (pend_vec[i]) begin
            pend_idx = ENTRY_DEPTH'(i);
            pend_any = 1'b1;
         end
      end
   end

   assign alloc_fire  = alloc_valid_i && alloc_ready_o;
   assign req_hs      = mem_req_valid_o && mem_req_ready_i;
   assign req_load_en = !mem_req_valid_o || mem_req_ready_i;
   assign load_fire   = req_load_en && pend_any;
   assign rsp_hit     = mem_rsp_valid_i && (entry_state[mem_rsp_id_i] == ST_WAIT_RSP);

   // Each event targets an entry in a different state, so the updates never collide.
   always_comb begin
      for (int i = 0; i < NUM_ENTRY; i++) entry_state_nxt[i] = entry_state[i];
      if (alloc_fire) entry_state_nxt[alloc_idx]    = ST_PENDING;
      if (load_fire)  entry_state_nxt[pend_idx]     = ST_ISSUING;
      if (req_hs)     entry_state_nxt[mem_req_id_o] = ST_WAIT_RSP;
      if (rsp_hit)    entry_state_nxt[mem_rsp_id_i] = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_ENTRY; i++) begin
            entry_state[i] <= ST_IDLE;
            entry_addr[i]  <= '0;
            entry_warp[i]  <= '0;
         end
         mem_req_valid_o <= 1'b0;
         mem_req_addr_o  <= '0;
         mem_req_id_o    <= '0;
         fill_valid_o    <= 1'b0;
         fill_addr_o     <= '0;
         fill_warp_id_o  <= '0;
         rsp_err_o       <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_ENTRY; i++) entry_state[i] <= entry_state_nxt[i];
         if (alloc_fire) begin
            entry_addr[alloc_idx] <= alloc_addr_i;
            entry_warp[alloc_idx] <= alloc_warp_id_i;
         end
         if (req_load_en) begin
            mem_req_valid_o <= pend_any;
            if (pend_any) begin
               mem_req_addr_o <= entry_addr[pend_idx];
               mem_req_id_o   <= pend_idx;
            end
         end
         fill_valid_o <= rsp_hit;
         rsp_err_o    <= mem_rsp_valid_i && !rsp_hit;
         if (rsp_hit) begin
            fill_addr_o    <= entry_addr[mem_rsp_id_i];
            fill_warp_id_o <= entry_warp[mem_rsp_id_i];
         end
      end
   end

endmodule

// File: tb/tb_icache_miss_entry_table.sv
// tb/tb_icache_miss_entry_table.sv - directed and randomized bench for icache_miss_entry_table
module tb_icache_miss_entry_table;

   localparam int NE = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        av;
   logic        alloc_ready;
   logic [31:0] aaddr;
   logic [2:0]  awarp;
   logic [3:0]  entry_valid;
   logic        full;
   logic        req_valid;
   logic        rdy;
   logic [31:0] req_addr;
   logic [1:0]  req_id;
   logic        rspv;
   logic [1:0]  rspid;
   logic        rsp_ready;
   logic        fill_valid;
   logic [31:0] fill_addr;
   logic [2:0]  fill_warp;
   logic        rsp_err;

   icache_miss_entry_table dut (
      .clk             (clk),
      .rst             (rst),
      .alloc_valid_i   (av),
      .alloc_ready_o   (alloc_ready),
      .alloc_addr_i    (aaddr),
      .alloc_warp_id_i (awarp),
      .entry_valid_o   (entry_valid),
      .full_o          (full),
      .mem_req_valid_o (req_valid),
      .mem_req_ready_i (rdy),
      .mem_req_addr_o  (req_addr),
      .mem_req_id_o    (req_id),
      .mem_rsp_valid_i (rspv),
      .mem_rsp_id_i    (rspid),
      .mem_rsp_ready_o (rsp_ready),
      .fill_valid_o    (fill_valid),
      .fill_addr_o     (fill_addr),
      .fill_warp_id_o  (fill_warp),
      .rsp_err_o       (rsp_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: 0 free, 1 waiting to issue, 2 in request slot, 3 awaiting refill
   int          m_st    [NE];
   logic [31:0] m_addr  [NE];
   logic [2:0]  m_warp  [NE];
   logic        m_rv;
   logic [31:0] m_raddr;
   int          m_rid;
   logic        m_fv;
   logic [31:0] m_faddr;
   logic [2:0]  m_fwarp;
   logic        m_err;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int lowest(input int code);
      for (int i = 0; i < NE; i++) if (m_st[i] == code) return i;
      return -1;
   endfunction

   function automatic int count(input int code);
      int c = 0;
      for (int i = 0; i < NE; i++) if (m_st[i] == code) c++;
      return c;
   endfunction

   function automatic logic [3:0] m_busy();
      logic [3:0] v = '0;
      for (int i = 0; i < NE; i++) v[i] = (m_st[i] != 0);
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NE; i++) begin
         m_st[i] = 0; m_addr[i] = '0; m_warp[i] = '0;
      end
      m_rv = 0; m_raddr = '0; m_rid = 0;
      m_fv = 0; m_faddr = '0; m_fwarp = '0; m_err = 0;
   endtask

   task automatic model_edge();
      int nst [NE];
      int k;
      if (rst) begin
         model_reset();
         return;
      end
      for (int i = 0; i < NE; i++) nst[i] = m_st[i];
      if (av && count(0) > 0) begin
         k = lowest(0);
         nst[k] = 1; m_addr[k] = aaddr; m_warp[k] = awarp;
      end
      if (m_rv && rdy) nst[m_rid] = 3;
      if (!m_rv || rdy) begin
         k = lowest(1);
         if (k >= 0) begin
            nst[k] = 2; m_rv = 1; m_raddr = m_addr[k]; m_rid = k;
         end else m_rv = 0;
      end
      m_fv = 0; m_err = 0;
      if (rspv) begin
         if (m_st[rspid] == 3) begin
            nst[rspid] = 0; m_fv = 1; m_faddr = m_addr[rspid]; m_fwarp = m_warp[rspid];
         end else m_err = 1;
      end
      for (int i = 0; i < NE; i++) m_st[i] = nst[i];
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      chk("entry_valid", 64'(entry_valid), 64'(m_busy()));
      chk("full", 64'(full), 64'(&m_busy()));
      chk("alloc_ready", 64'(alloc_ready), 64'(!(&m_busy())));
      chk("req_valid", 64'(req_valid), 64'(m_rv));
      chk("req_addr", 64'(req_addr), 64'(m_raddr));
      chk("req_id", 64'(req_id), 64'(m_rid));
      chk("fill_valid", 64'(fill_valid), 64'(m_fv));
      chk("fill_addr", 64'(fill_addr), 64'(m_faddr));
      chk("fill_warp", 64'(fill_warp), 64'(m_fwarp));
      chk("rsp_err", 64'(rsp_err), 64'(m_err));
      chk("rsp_ready", 64'(rsp_ready), 64'(1));
   endtask

   initial begin
      logic [31:0] fill_exp [4];
      int          ids      [4];
      int          guard;
      model_reset();
      rst = 1; av = 0; aaddr = '0; awarp = '0; rdy = 0; rspv = 0; rspid = '0;
      #1;
      tick(); tick();
      chk("reset_alloc_ready", 64'(alloc_ready), 64'(1));
      rst = 0;

      // single miss: issue at T+2, refill
      av = 1; aaddr = 32'h100; awarp = 3'd2; rdy = 1;
      tick();
      av = 0;
      tick();
      chk("t1_req_valid", 64'(req_valid), 64'(1));
      chk("t1_req_addr", 64'(req_addr), 64'h100);
      chk("t1_req_id", 64'(req_id), 64'(0));
      tick();
      rspv = 1; rspid = 2'd0;
      tick();
      chk("t1_fill_valid", 64'(fill_valid), 64'(1));
      chk("t1_fill_addr", 64'(fill_addr), 64'h100);
      chk("t1_fill_warp", 64'(fill_warp), 64'(2));
      chk("t1_empty", 64'(entry_valid), 64'(0));
      rspv = 0;
      tick();

      // fill up with memory stalled
      rdy = 0;
      for (int i = 0; i < 4; i++) begin
         av = 1; aaddr = 32'((i + 1) * 32'h100); awarp = 3'(i);
         tick();
      end
      chk("t2_full", 64'(full), 64'(1));
      chk("t2_alloc_ready", 64'(alloc_ready), 64'(0));
      chk("t2_valid", 64'(entry_valid), 64'hf);
      aaddr = 32'h500;
      tick();
      av = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t2_stall_addr", 64'(req_addr), 64'h100);
         chk("t2_stall_id", 64'(req_id), 64'(0));
      end

      // drain requests, then free entry 2 while allocating
      rdy = 1;
      guard = 0;
      while (count(3) != 4 && guard < 20) begin tick(); guard++; end
      chk("t3_all_wait", 64'(count(3)), 64'(4));
      rspv = 1; rspid = 2'd2; av = 1; aaddr = 32'h900; awarp = 3'd5;
      tick();
      chk("t3_not_taken", 64'(entry_valid), 64'hb);
      rspv = 0;
      tick();
      av = 0;
      chk("t3_realloc", 64'(entry_valid), 64'hf);
      tick();
      chk("t3_req_id", 64'(req_id), 64'(2));
      chk("t3_req_addr", 64'(req_addr), 64'h900);
      tick();

      // out-of-order responses
      ids = '{3, 0, 1, 2};
      fill_exp = '{32'h400, 32'h100, 32'h200, 32'h900};
      for (int i = 0; i < 4; i++) begin
         rspv = 1; rspid = 2'(ids[i]);
         tick();
         chk("t4_fill_valid", 64'(fill_valid), 64'(1));
         chk("t4_fill_addr", 64'(fill_addr), 64'(fill_exp[i]));
      end
      rspv = 0;
      chk("t4_empty", 64'(entry_valid), 64'(0));

      // response to an idle entry
      rspv = 1; rspid = 2'd1;
      tick();
      chk("t5_err", 64'(rsp_err), 64'(1));
      chk("t5_no_fill", 64'(fill_valid), 64'(0));
      chk("t5_valid", 64'(entry_valid), 64'(0));
      rspv = 0;
      tick();

      // reset with live entries and a held request
      rdy = 1;
      for (int i = 0; i < 3; i++) begin
         av = 1; aaddr = 32'(32'hA00 + i * 32'h100); awarp = 3'(i + 1);
         tick();
      end
      av = 0;
      guard = 0;
      while (count(3) < 2 && guard < 20) begin tick(); guard++; end
      rdy = 0;
      tick();
      chk("t6_held", 64'(req_valid), 64'(1));
      rst = 1;
      tick();
      chk("t6_rst_valid", 64'(entry_valid), 64'(0));
      chk("t6_rst_req", 64'(req_valid), 64'(0));
      rst = 0;
      rspv = 1; rspid = 2'd0;
      tick();
      chk("t6_err", 64'(rsp_err), 64'(1));
      rspv = 0;

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rst   = ($urandom_range(0, 299) == 0);
         av    = ($urandom_range(0, 1) == 1);
         aaddr = $urandom & 32'hffff_ffc0;
         awarp = 3'($urandom);
         rdy   = ($urandom_range(0, 9) < 7);
         rspv  = ($urandom_range(0, 2) != 0);
         if (count(3) > 0 && $urandom_range(0, 9) < 8) begin
            int pick;
            pick = $urandom_range(0, NE - 1);
            while (m_st[pick] != 3) pick = (pick + 1) % NE;
            rspid = 2'(pick);
         end else rspid = 2'($urandom);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/icache_miss_entry_table.md
Name: icache_miss_entry_table

Overview:
- I-cache miss-tracking table sitting between the i-cache tag lookup and the L2/memory request port.
- On each i-cache miss it allocates the lowest-index free entry, holding the line address and requesting warp id.
- It issues one memory request per entry and frees the entry when the matching refill response returns, then presents the refill to the cache data array.
- It exports the per-entry occupancy vector consumed by the entry-status finder logic.

Parameters:
- NUM_ENTRY, 4, number of miss entries.
- ENTRY_DEPTH, 2, width of entry index; equals clog2(NUM_ENTRY).
- ADDR_WIDTH, 32, line address width.
- WARP_ID_WIDTH, 3, warp id width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- alloc_valid_i  in  1  miss allocation request.
- alloc_ready_o  out  1  at least one entry IDLE (current state only, no bypass).
- alloc_addr_i  in  ADDR_WIDTH  missing line address.
- alloc_warp_id_i  in  WARP_ID_WIDTH  requesting warp.
- entry_valid_o  out  NUM_ENTRY  bit i = 1 when entry i not IDLE.
- full_o  out  1  AND of entry_valid_o.
- mem_req_valid_o  out  1  registered memory request valid.
- mem_req_ready_i  in  1  memory accepts request.
- mem_req_addr_o  out  ADDR_WIDTH  request line address.
- mem_req_id_o  out  ENTRY_DEPTH  entry index used as transaction tag.
- mem_rsp_valid_i  in  1  refill response valid.
- mem_rsp_id_i  in  ENTRY_DEPTH  response tag.
- mem_rsp_ready_o  out  1  tied 1; responses always accepted.
- fill_valid_o  out  1  one-cycle refill pulse.
- fill_addr_o  out  ADDR_WIDTH  refilled line address.
- fill_warp_id_o  out  WARP_ID_WIDTH  warp to wake.
- rsp_err_o  out  1  one-cycle pulse: response tag not in WAIT_RSP.

Behaviour:
- Per-entry state: IDLE, PENDING, ISSUING, WAIT_RSP.
  - IDLE -> PENDING on allocation.
  - PENDING -> ISSUING when loaded into the request register.
  - ISSUING -> WAIT_RSP on mem_req handshake.
  - WAIT_RSP -> IDLE on matching response.
- Reset:
  - All entries go IDLE.
  - mem_req_valid_o, fill_valid_o, rsp_err_o, entry_valid_o and full_o are 0.
  - Address, id and warp outputs are 0.
  - alloc_ready_o is 1.
  - Reset mid-operation discards all entries and any held request.
  - Later responses hit IDLE entries and pulse rsp_err_o.
- Allocation:
  - Fires when alloc_valid_i && alloc_ready_o.
  - Writes to the lowest-index IDLE entry; the entry becomes PENDING at T+1.
  - alloc_ready_o = !full_o.
  - Duplicate addresses are allowed (no merge).
- Issue:
  - The request register loads when empty, or in the same cycle its current request handshakes.
  - It loads the lowest-index PENDING entry, which becomes ISSUING.
  - mem_req_valid_o, addr and id are held stable while valid && !ready.
  - Minimum latency: alloc at T, PENDING at T+1, mem_req_valid_o at T+2.
  - Back-to-back issue at 1 request per cycle when ready is held high.
- Response:
  - mem_rsp_valid_i at T with tag k in WAIT_RSP causes entry k to be IDLE at T+1.
  - At T+1, fill_valid_o=1 with entry k address and warp.
  - A tag in any other state leaves state unchanged and pulses rsp_err_o at T+1, with fill_valid_o=0.
- Simultaneous events:
  - A response freeing entry k and an allocation in the same cycle: the allocation uses pre-cycle IDLE set only.
  - When full, the freed entry becomes allocatable from T+1.
  - Allocation, issue load and response may all occur in one cycle on distinct entries.
- fill_addr_o and fill_warp_id_o hold their last values when fill_valid_o=0.

Test Plan:
- Reset, then 1 alloc (addr 0x100, warp 2) with mem_req_ready_i=1 -> T+2 mem_req_valid_o=1, addr 0x100, id 0. Respond id 0 -> next cycle fill_valid_o=1, fill_addr_o=0x100, fill_warp_id_o=2, entry_valid_o=0000.
- 4 back-to-back allocs (0x100..0x400), mem_req_ready_i=0 -> full_o=1, alloc_ready_o=0, entry_valid_o=1111. 5th alloc is not accepted. mem_req_addr_o stays 0x100, id 0, for 10 stalled cycles.
- Table full with entries 0-3 in WAIT_RSP. Respond id 2 while alloc_valid_i=1 (0x900) -> alloc not taken that cycle. Next cycle alloc lands in entry 2, and entry 2's request is id 2, addr 0x900.
- Out-of-order responses: ids 3, 0, 1, 2 -> four fill pulses in that order with matching addresses, and the table returns to empty.
- Response id 1 while entry 1 IDLE -> rsp_err_o pulse, no fill, entry_valid_o unchanged.
- Reset asserted with 2 entries WAIT_RSP and a held request -> all outputs 0 next cycle. Later response id 0 -> rsp_err_o=1.
